// File: rtl/box_area_seq.sv
// Sequential box-area unit: |x1-x0| * |y1-y0| via a one-bit-per-cycle shift-add multiplier.
// Optional saturating area accumulator is built when BOX_AREA_ACC_EN is defined.
module box_area_seq #(
    parameter int COORD_W = 4,
    parameter int ACC_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COORD_W-1:0]     x0,
    input  logic [COORD_W-1:0]     y0,
    input  logic [COORD_W-1:0]     x1,
    input  logic [COORD_W-1:0]     y1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*COORD_W-1:0]   area,
    output logic                   area_zero,
    input  logic                   acc_clr,
    output logic [ACC_W-1:0]       acc,
    output logic                   acc_sat
);

    localparam int PROD_W = 2 * COORD_W;
    localparam int CNT_W  = $clog2(COORD_W + 1);
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(COORD_W);

    typedef enum logic [1:0] {
        IDLE,
        DIFF,
        MUL,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [COORD_W-1:0] w_dx, w_dy;
    logic [PROD_W-1:0]  r_mcand;
    logic [COORD_W-1:0] r_mplier;
    logic [PROD_W-1:0]  r_prod;
    logic [PROD_W-1:0]  r_area;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_in_xfer;
    logic               w_out_xfer;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign area       = r_area;
    assign area_zero  = (r_area == '0);

    assign w_dx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_dy = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_in_xfer) w_next = DIFF;
            DIFF: w_next = MUL;
            MUL:  if (r_cnt == STEPS) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // MUL runs COORD_W add steps, then one cycle publishing the product into
    // the area register so area stays stable outside DONE as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_area   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        r_x0 <= x0;
                        r_y0 <= y0;
                        r_x1 <= x1;
                        r_y1 <= y1;
                    end
                end
                DIFF: begin
                    r_mcand  <= {{COORD_W{1'b0}}, w_dx};
                    r_mplier <= w_dy;
                    r_prod   <= '0;
                    r_cnt    <= '0;
                end
                MUL: begin
                    if (r_cnt != STEPS) begin
                        if (r_mplier[0]) begin
                            r_prod <= r_prod + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end else begin
                        r_area <= r_prod;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOX_AREA_ACC_EN
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W:0]   w_acc_sum;

    // A clear coinciding with a result transfer restarts the sum at that area.
    assign w_acc_base = acc_clr ? '0 : r_acc;
    assign w_acc_sum  = {1'b0, w_acc_base} + (ACC_W + 1)'(r_area);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_out_xfer) begin
            r_acc     <= w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
            r_acc_sat <= (r_acc_sat & ~acc_clr) | w_acc_sum[ACC_W];
        end else if (acc_clr) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end
    end

    assign acc     = r_acc;
    assign acc_sat = r_acc_sat;
`else
    logic w_unused_acc_clr;
    logic w_unused_out_xfer;

    assign w_unused_acc_clr  = acc_clr;
    assign w_unused_out_xfer = w_out_xfer;
    assign acc               = '0;
    assign acc_sat           = 1'b0;
`endif

endmodule

// File: tb/tb_box_area_seq.sv
// Self-checking bench for box_area_seq: directed test-plan cases plus random
// operations, checked every cycle against a transaction-level reference model.
module tb_box_area_seq;

    localparam int W     = 4;
    localparam int AW    = 12;
    localparam int LAT   = W + 2;
    localparam longint ACC_MAX = (longint'(1) << AW) - 1;
`ifdef BOX_AREA_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x0, y0, x1, y1;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  area;
    logic            area_zero;
    logic            acc_clr;
    logic [AW-1:0]   acc;
    logic            acc_sat;

    box_area_seq #(
        .COORD_W (W),
        .ACC_W   (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .area      (area),
        .area_zero (area_zero),
        .acc_clr   (acc_clr),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint adiff(input int a, input int b);
        return (a >= b) ? longint'(a - b) : longint'(b - a);
    endfunction

    // Reference model: a transaction is busy for LAT cycles, then presents its
    // result until accepted; area shows the last finished result.
    bit     m_init = 1'b0;
    bit     m_busy, m_done, m_sat;
    int     m_cnt;
    longint m_pend, m_area_out, m_acc;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init     = 1'b1;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_cnt      = 0;
            m_pend     = 0;
            m_area_out = 0;
            m_acc      = 0;
            m_sat      = 1'b0;
        end else if (m_init) begin
            if (m_done && out_ready) begin
                longint sum;
                sum = (acc_clr ? 0 : m_acc) + m_area_out;
                m_sat = acc_clr ? 1'b0 : m_sat;
                if (sum > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_sat = 1'b1;
                end else begin
                    m_acc = sum;
                end
                m_done = 1'b0;
                m_busy = 1'b0;
            end else begin
                if (acc_clr) begin
                    m_acc = 0;
                    m_sat = 1'b0;
                end
                if (m_busy && !m_done) begin
                    m_cnt++;
                    if (m_cnt == LAT) begin
                        m_done     = 1'b1;
                        m_area_out = m_pend;
                    end
                end else if (!m_busy && in_valid) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_pend = adiff(int'(x1), int'(x0)) * adiff(int'(y1), int'(y0));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready",  longint'(in_ready),  longint'(!m_busy));
            chk("out_valid", longint'(out_valid), longint'(m_done));
            chk("area",      longint'(area),      m_area_out);
            chk("area_zero", longint'(area_zero), longint'(m_area_out == 0));
            chk("acc",       longint'(acc),       ACC_ON ? m_acc : 0);
            chk("acc_sat",   longint'(acc_sat),   ACC_ON ? longint'(m_sat) : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_coords();
        x0 = W'($urandom_range(0, 15));
        y0 = W'($urandom_range(0, 15));
        x1 = W'($urandom_range(0, 15));
        y1 = W'($urandom_range(0, 15));
    endtask

    task automatic send(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int stall, input bit clr,
                        output longint got, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        chk("in_ready_wait", longint'(guard < 100), 1);
        x0 = W'(ax0);
        y0 = W'(ay0);
        x1 = W'(ax1);
        y1 = W'(ay1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        randomize_coords();
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("out_valid_wait", longint'(lat < 100), 1);
        got = longint'(area);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            randomize_coords();
            step();
        end
        in_valid  = 1'b0;
        acc_clr   = clr;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        acc_clr   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint got;
        int     lat;
        int     stray;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc_clr   = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) step();
        chk("rst_in_ready",  longint'(in_ready),  1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_area",      longint'(area),      0);
        chk("rst_area_zero", longint'(area_zero), 1);
        chk("rst_acc",       longint'(acc),       0);
        rst_n = 1'b1;
        step();

        send(3, 1, 7, 5, 0, 1'b0, got, lat);
        chk("basic_area", got, 16);
        chk("basic_latency", longint'(lat), 6);
        chk("basic_area_zero", longint'(area_zero), 0);

        send(15, 15, 0, 0, 0, 1'b0, got, lat);
        chk("rev_area", got, 225);
        send(0, 0, 15, 15, 0, 1'b0, got, lat);
        chk("fwd_area", got, 225);

        send(9, 2, 9, 14, 0, 1'b0, got, lat);
        chk("degen_area", got, 0);
        chk("degen_area_zero", longint'(area_zero), 1);

        send(2, 3, 5, 9, 10, 1'b0, got, lat);
        chk("bp_area", got, 18);
        chk("bp_in_ready_after", longint'(in_ready), 1);

        x0 = 4'd15; y0 = 4'd15; x1 = 4'd0; y1 = 4'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("mulrst_out_valid", longint'(out_valid), 0);
        chk("mulrst_area",      longint'(area),      0);
        chk("mulrst_in_ready",  longint'(in_ready),  1);
        chk("mulrst_acc",       longint'(acc),       0);
        rst_n = 1'b1;
        stray = 0;
        repeat (15) begin
            step();
            if (out_valid) stray++;
        end
        chk("mulrst_no_stray", longint'(stray), 0);

        for (int i = 1; i <= 19; i++) begin
            send(15, 15, 0, 0, 0, 1'b0, got, lat);
            if (i == 18) begin
                chk("acc18", longint'(acc), ACC_ON ? 4050 : 0);
                chk("acc18_sat", longint'(acc_sat), 0);
            end
        end
        chk("acc19", longint'(acc), ACC_ON ? 4095 : 0);
        chk("acc19_sat", longint'(acc_sat), ACC_ON ? 1 : 0);
        send(3, 1, 7, 5, 0, 1'b1, got, lat);
        chk("acc_clr_xfer", longint'(acc), ACC_ON ? 16 : 0);
        chk("acc_clr_sat", longint'(acc_sat), 0);

        for (int n = 0; n < 60; n++) begin
            int rx0, ry0, rx1, ry1;
            rx0 = int'($urandom_range(0, 15));
            ry0 = int'($urandom_range(0, 15));
            rx1 = int'($urandom_range(0, 15));
            ry1 = int'($urandom_range(0, 15));
            send(rx0, ry0, rx1, ry1, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), got, lat);
            chk("rand_area", got, adiff(rx1, rx0) * adiff(ry1, ry0));
            chk("rand_latency", longint'(lat), LAT);
            repeat ($urandom_range(0, 2)) begin
                acc_clr = ($urandom_range(0, 9) == 0);
                step();
            end
            acc_clr = 1'b0;
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
